// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the program loader: the loader state encoding, the
// number of bytes per instruction word and the word-address helper.
// No ports (package).
// -----------------------------------------------------------------------------
package loader_pkg;

    // Loader states: collect length header, stream words, finished, rejected.
    typedef enum logic [1:0] {
        ST_LEN   = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int INDEX_W        = 16;

    // Byte address of word 'index' relative to 'base'; wraps modulo 2^32.
    function automatic logic [31:0] word_address(input logic [31:0] base,
                                                 input logic [INDEX_W-1:0] index);
        word_address = base + {14'd0, index, 2'b00};
    endfunction

endpackage

// File: rtl/program_loader_byte_assembler.sv
// -----------------------------------------------------------------------------
// byte_assembler
// Collects big-endian bytes into 32-bit words. The first byte of each group
// of four lands in bits [31:24].
// Ports:
//   clock         : rising-edge clock
//   clear         : synchronous active-high reset
//   accept        : a byte transfers on this edge (in_valid && in_ready)
//   in_data       : the byte being transferred
//   word          : assembled word, valid while word_complete is high
//   word_complete : high in the cycle the fourth byte of a word is accepted
// -----------------------------------------------------------------------------
module byte_assembler
    import loader_pkg::*;
(
    input  logic        clock,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  in_data,
    output logic [31:0] word,
    output logic        word_complete
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [23:0] shift_r;
    logic [1:0]  count_r;

    // Byte shift register and byte counter; both move only on a handshake.
    always_ff @(posedge clock) begin
        if (clear) begin
            shift_r <= 24'd0;
            count_r <= 2'd0;
        end else if (accept) begin
            shift_r <= {shift_r[15:0], in_data};
            count_r <= count_r + 2'd1;
        end else begin
            shift_r <= shift_r;
            count_r <= count_r;
        end
    end

    // The fourth byte is still on in_data, so the word is completed combinationally
    // and the consumer can register it on the same edge as the handshake.
    always_comb begin
        word          = {shift_r, in_data};
        word_complete = accept && (count_r == LAST_BYTE);
    end

endmodule

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
// Receives a byte stream (4-byte big-endian word count N followed by N
// big-endian instruction words) and writes the words into instruction memory
// starting at BASE_ADDR, holding the CPU in clear until the load completes.
// Parameters:
//   MEM_WORDS : instruction-memory capacity in words (largest accepted N)
//   BASE_ADDR : byte address of the first word (word-aligned)
// Ports:
//   clock, clear            : clock and synchronous active-high reset
//   in_valid, in_data       : byte-stream source
//   in_ready                : loader accepts a byte this cycle
//   imem_write              : one-cycle write strobe
//   imem_address, imem_data : write address / word, held between strobes
//   cpu_clear               : keeps the datapath in clear until DONE
//   done, error             : load finished / header length too large
// -----------------------------------------------------------------------------
module program_loader
    import loader_pkg::*;
#(
    parameter int          MEM_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
)(
    input  logic        clock,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        imem_write,
    output logic [31:0] imem_address,
    output logic [31:0] imem_data,
    output logic        cpu_clear,
    output logic        done,
    output logic        error
);

    state_t               state_r;
    state_t               state_s;
    logic [INDEX_W-1:0]   index_r;
    logic [INDEX_W-1:0]   n_r;
    logic                 imem_write_r;
    logic [31:0]          imem_address_r;
    logic [31:0]          imem_data_r;
    logic                 cpu_clear_r;
    logic                 done_r;
    logic                 error_r;

    logic                 in_ready_s;
    logic                 accept_s;
    logic                 last_written_s;
    logic [31:0]          word_s;
    logic                 word_complete_s;

    byte_assembler u_byte_assembler (
        .clock         (clock),
        .clear         (clear),
        .accept        (accept_s),
        .in_data       (in_data),
        .word          (word_s),
        .word_complete (word_complete_s)
    );

    // The strobe of the final word is in flight: index has already advanced to N.
    // Bytes are refused in this cycle so nothing leaks past the end of the program.
    always_comb begin
        last_written_s = imem_write_r && (index_r == n_r);
    end

    // Ready is combinational so that a clear cycle blocks the handshake immediately.
    always_comb begin
        in_ready_s = 1'b0;
        if (clear) begin
            in_ready_s = 1'b0;
        end else begin
            case (state_r)
                ST_LEN:  in_ready_s = 1'b1;
                ST_LOAD: in_ready_s = !last_written_s;
                default: in_ready_s = 1'b0;
            endcase
        end
        accept_s = in_valid && in_ready_s;
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_LEN: begin
                if (word_complete_s) begin
                    if (word_s == 32'd0) begin
                        state_s = ST_DONE;
                    end else if (word_s > 32'(MEM_WORDS)) begin
                        state_s = ST_ERROR;
                    end else begin
                        state_s = ST_LOAD;
                    end
                end else begin
                    state_s = ST_LEN;
                end
            end
            ST_LOAD: begin
                if (last_written_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_DONE:  state_s = ST_DONE;
            ST_ERROR: state_s = ST_ERROR;
            default:  state_s = ST_LEN;
        endcase
    end

    // State, word index, length and write-port registers.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_r        <= ST_LEN;
            index_r        <= 16'd0;
            n_r            <= 16'd0;
            imem_write_r   <= 1'b0;
            imem_address_r <= BASE_ADDR;
            imem_data_r    <= 32'd0;
            cpu_clear_r    <= 1'b1;
            done_r         <= 1'b0;
            error_r        <= 1'b0;
        end else begin
            state_r      <= state_s;
            imem_write_r <= 1'b0;
            if ((state_r == ST_LEN) && word_complete_s) begin
                // Only the low bits matter once the length passed the capacity check.
                n_r     <= word_s[INDEX_W-1:0];
                index_r <= 16'd0;
            end
            if ((state_r == ST_LOAD) && word_complete_s) begin
                imem_write_r   <= 1'b1;
                imem_address_r <= word_address(BASE_ADDR, index_r);
                imem_data_r    <= word_s;
                index_r        <= index_r + 16'd1;
            end
            cpu_clear_r <= (state_s != ST_DONE);
            done_r      <= (state_s == ST_DONE);
            error_r     <= (state_s == ST_ERROR);
        end
    end

    assign in_ready     = in_ready_s;
    assign imem_write   = imem_write_r;
    assign imem_address = imem_address_r;
    assign imem_data    = imem_data_r;
    assign cpu_clear    = cpu_clear_r;
    assign done         = done_r;
    assign error        = error_r;

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
// Two loaders (BASE_ADDR 0x0 and 0x100) share one byte stream. Each expected
// memory write (address, word, cycle) is queued when its last byte is driven;
// per-instance monitors pop and compare whenever imem_write is seen.
// -----------------------------------------------------------------------------
module tb_program_loader;
    import loader_pkg::*;

    localparam logic [31:0] BASE0 = 32'h0000_0000;
    localparam logic [31:0] BASE1 = 32'h0000_0100;
    localparam int          MEMW  = 256;

    logic        clock = 1'b0;
    logic        clear;
    logic        in_valid;
    logic [7:0]  in_data;

    logic        in_ready0, imem_write0, cpu_clear0, done0, error0;
    logic [31:0] addr0, data0;
    logic        in_ready1, imem_write1, cpu_clear1, done1, error1;
    logic [31:0] addr1, data1;

    program_loader #(.MEM_WORDS(MEMW), .BASE_ADDR(BASE0)) dut0 (
        .clock(clock), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready0), .imem_write(imem_write0), .imem_address(addr0),
        .imem_data(data0), .cpu_clear(cpu_clear0), .done(done0), .error(error0)
    );

    program_loader #(.MEM_WORDS(MEMW), .BASE_ADDR(BASE1)) dut1 (
        .clock(clock), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready1), .imem_write(imem_write1), .imem_address(addr1),
        .imem_data(data1), .cpu_clear(cpu_clear1), .done(done1), .error(error1)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         q0[$];
    wr_t         q1[$];
    logic [31:0] words[$];
    int          checks   = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for instance 0: every strobe must match the oldest expected write.
    always @(negedge clock) begin
        if (q0.size() > 0 && q0[0].cyc < cyc) begin
            checks++; failures++;
            $display("FAIL missed_write0: no strobe, expected addr %h at cycle %0d", q0[0].addr, q0[0].cyc);
            void'(q0.pop_front());
        end
        if (imem_write0 === 1'b1) begin
            if (q0.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_write0: addr %h data %h, expected none", addr0, data0);
            end else begin
                wr_t e;
                e = q0.pop_front();
                chk("wr0_addr", addr0, e.addr);
                chk("wr0_data", data0, e.data);
                chk("wr0_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Monitor for instance 1.
    always @(negedge clock) begin
        if (q1.size() > 0 && q1[0].cyc < cyc) begin
            checks++; failures++;
            $display("FAIL missed_write1: no strobe, expected addr %h at cycle %0d", q1[0].addr, q1[0].cyc);
            void'(q1.pop_front());
        end
        if (imem_write1 === 1'b1) begin
            if (q1.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_write1: addr %h data %h, expected none", addr1, data1);
            end else begin
                wr_t e;
                e = q1.pop_front();
                chk("wr1_addr", addr1, e.addr);
                chk("wr1_data", data1, e.data);
                chk("wr1_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the byte was taken.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit last,
                             input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] w);
        while (int'($urandom_range(99)) < gap) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(negedge clock);
        end
        in_valid = 1'b1;
        in_data  = b;
        #1;
        chk("in_ready0", {31'd0, in_ready0}, 32'd1);
        chk("in_ready1", {31'd0, in_ready1}, 32'd1);
        if (last) begin
            q0.push_back('{cyc + 1, a0, w});
            q1.push_back('{cyc + 1, a1, w});
        end
        @(negedge clock);
    endtask

    task automatic check_status(input string tag, input logic rdy, input logic cc,
                                input logic dn, input logic er);
        chk({tag, "_ready0"}, {31'd0, in_ready0}, {31'd0, rdy});
        chk({tag, "_ready1"}, {31'd0, in_ready1}, {31'd0, rdy});
        chk({tag, "_cpu_clear0"}, {31'd0, cpu_clear0}, {31'd0, cc});
        chk({tag, "_cpu_clear1"}, {31'd0, cpu_clear1}, {31'd0, cc});
        chk({tag, "_done0"}, {31'd0, done0}, {31'd0, dn});
        chk({tag, "_done1"}, {31'd0, done1}, {31'd0, dn});
        chk({tag, "_error0"}, {31'd0, error0}, {31'd0, er});
        chk({tag, "_error1"}, {31'd0, error1}, {31'd0, er});
    endtask

    // One-cycle clear pulse from a negedge, then the full reset-state check.
    task automatic do_clear();
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        #1;
        chk("ready_in_clear0", {31'd0, in_ready0}, 32'd0);
        chk("ready_in_clear1", {31'd0, in_ready1}, 32'd0);
        @(negedge clock);
        clear    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_status("reset", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("reset_write0", {31'd0, imem_write0}, 32'd0);
        chk("reset_addr0", addr0, BASE0);
        chk("reset_addr1", addr1, BASE1);
        chk("reset_data0", data0, 32'd0);
        @(negedge clock);
    endtask

    // Idle with random traffic in a terminal state; nothing may change.
    task automatic hold_terminal(input string tag, input logic cc, input logic dn, input logic er);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'(($urandom));
            in_data  = 8'($urandom);
            #1;
            check_status(tag, 1'b0, cc, dn, er);
            @(negedge clock);
        end
    endtask

    // Header N, then the first N entries of 'words'; optional clear after
    // clear_after payload bytes.
    task automatic run_load(input logic [31:0] n, input int gap, input int clear_after);
        int cnt = 0;
        for (int j = 0; j < BYTES_PER_WORD; j++)
            send_byte(8'(n >> (24 - 8 * j)), gap, 1'b0, 32'd0, 32'd0, 32'd0);
        if (n == 32'd0) begin
            hold_terminal("len0", 1'b0, 1'b1, 1'b0);
        end else if (n > 32'(MEMW)) begin
            hold_terminal("too_long", 1'b1, 1'b0, 1'b1);
        end else begin
            for (int i = 0; i < int'(n); i++) begin
                for (int j = 0; j < BYTES_PER_WORD; j++) begin
                    cnt++;
                    send_byte(8'(words[i] >> (24 - 8 * j)), gap, j == BYTES_PER_WORD - 1,
                              BASE0 + 32'(4 * i), BASE1 + 32'(4 * i), words[i]);
                    if (clear_after >= 0 && cnt == clear_after) begin
                        do_clear();
                        return;
                    end
                end
            end
            // Strobe cycle of the last word: still loading, bytes refused.
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            #1;
            check_status("last_strobe", 1'b0, 1'b1, 1'b0, 1'b0);
            @(negedge clock);
            #1;
            chk("after_last_write0", {31'd0, imem_write0}, 32'd0);
            hold_terminal("done", 1'b0, 1'b1, 1'b0);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        clear    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'd0;
        repeat (2) @(negedge clock);
        do_clear();

        // Directed three-word program.
        words = '{32'h0102_0304, 32'hAABB_CCDD, 32'hDEAD_BEEF};
        run_load(32'd3, 0, -1);
        do_clear();

        // Empty program and lengths past capacity.
        run_load(32'd0, 0, -1);
        do_clear();
        run_load(32'd257, 0, -1);
        do_clear();
        run_load(32'h0001_0000, 0, -1);
        do_clear();

        // Same two words without and with input gaps.
        words.delete();
        words.push_back($urandom);
        words.push_back($urandom);
        run_load(32'd2, 0, -1);
        do_clear();
        run_load(32'd2, 50, -1);
        do_clear();

        // Clear in the middle of the second word, then a one-word reload.
        run_load(32'd2, 0, 6);
        words = '{32'h1122_3344};
        run_load(32'd1, 0, -1);
        do_clear();

        // Random lengths, contents and gap densities.
        for (int r = 0; r < 6; r++) begin
            int n;
            n = int'($urandom_range(8, 1));
            words.delete();
            for (int i = 0; i < n; i++) words.push_back($urandom);
            run_load(32'(n), int'($urandom_range(60)), -1);
            do_clear();
        end

        // Largest accepted program.
        words.delete();
        for (int i = 0; i < MEMW; i++) words.push_back($urandom);
        run_load(32'(MEMW), 0, -1);
        do_clear();

        repeat (3) @(negedge clock);
        chk("queue0_empty", 32'(q0.size()), 32'd0);
        chk("queue1_empty", 32'(q1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
